key_event_ctrl: RTL

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_event_pkg.sv | 23 ++
 rtl/key_event_chan.sv | 163 ++++++++++++++++
 rtl/key_event_ctrl.sv | 54 +++++
 3 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg: shared definitions for the key event controller.
//   key_state_e : per-channel debounce / hold state machine encoding
//   cnt_width() : width of a counter that must hold values 0..max_val
package key_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DB_DOWN = 3'd1,
    ST_HELD    = 3'd2,
    ST_LONG    = 3'd3,
    ST_DB_UP   = 3'd4
  } key_state_e;

  // A counter never narrower than one bit, even for a degenerate maximum.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/key_event_chan.sv
// key_event_chan: one key channel -- synchroniser, debounce, press/long/
// repeat/release event generation.
// Optional feature: define KEY_REPEAT_EN to build the auto-repeat counter;
// without it repeat_pulse is tied low and no repeat counter exists.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   key_raw        : raw asynchronous key pin
//   key_en         : channel enable, 0 holds the channel idle
//   key_level      : debounced level, 1 = pressed
//   press_pulse, release_pulse, long_pulse, repeat_pulse : 1-cycle strobes
module key_event_chan
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 200000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  input  logic key_en,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam logic RELEASED_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam int   DB_W         = cnt_width(DEBOUNCE_CYC);
  localparam int   LG_W         = cnt_width(LONG_CYC);
  // The transition fires on the sample that would bring the count to N.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYC - 1);
  localparam logic [DB_W-1:0] DB_MAX  = {DB_W{1'b1}};
  localparam logic [LG_W-1:0] LG_MAX  = {LG_W{1'b1}};

  logic       sync1_r;
  logic       sync2_r;
  logic       pressed_s;
  key_state_e state_r;
  key_state_e prior_r;       // HELD or LONG, restored after a release bounce
  logic [DB_W-1:0] db_cnt_r;
  logic [LG_W-1:0] hold_cnt_r;

`ifdef KEY_REPEAT_EN
  localparam int RP_W = cnt_width(REPEAT_CYC);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYC - 1);
  localparam logic [RP_W-1:0] RP_MAX  = {RP_W{1'b1}};
  logic [RP_W-1:0] rep_cnt_r;
`else
  assign repeat_pulse = 1'b0;
`endif

  // Two-flop synchroniser; reset preloads the released level so a key held
  // through reset is seen as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= RELEASED_RAW;
      sync2_r <= RELEASED_RAW;
    end else begin
      sync1_r <= key_raw;
      sync2_r <= sync1_r;
    end
  end

  assign pressed_s = (ACTIVE_LOW != 0) ? ~sync2_r : sync2_r;

  // Channel state machine with its counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst || !key_en) begin
      state_r       <= ST_IDLE;
      prior_r       <= ST_HELD;
      db_cnt_r      <= {DB_W{1'b0}};
      hold_cnt_r    <= {LG_W{1'b0}};
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_r     <= {RP_W{1'b0}};
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (pressed_s) begin
            state_r  <= ST_DB_DOWN;
            db_cnt_r <= {DB_W{1'b0}};
          end
        end
        ST_DB_DOWN: begin
          if (!pressed_s) begin
            state_r <= ST_IDLE;
          end else if (db_cnt_r >= DB_LAST) begin
            state_r     <= ST_HELD;
            hold_cnt_r  <= {LG_W{1'b0}};
            key_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else if (db_cnt_r != DB_MAX) begin
            db_cnt_r <= db_cnt_r + 1'b1;
          end
        end
        ST_HELD: begin
          if (!pressed_s) begin
            state_r  <= ST_DB_UP;
            prior_r  <= ST_HELD;
            db_cnt_r <= {DB_W{1'b0}};
          end else if (hold_cnt_r >= LG_LAST) begin
            state_r    <= ST_LONG;
            long_pulse <= 1'b1;
`ifdef KEY_REPEAT_EN
            rep_cnt_r  <= {RP_W{1'b0}};
`endif
          end else if (hold_cnt_r != LG_MAX) begin
            hold_cnt_r <= hold_cnt_r + 1'b1;
          end
        end
        ST_LONG: begin
          if (!pressed_s) begin
            state_r  <= ST_DB_UP;
            prior_r  <= ST_LONG;
            db_cnt_r <= {DB_W{1'b0}};
          end
`ifdef KEY_REPEAT_EN
          else if (rep_cnt_r >= RP_LAST) begin
            repeat_pulse <= 1'b1;
            rep_cnt_r    <= {RP_W{1'b0}};
          end else if (rep_cnt_r != RP_MAX) begin
            rep_cnt_r <= rep_cnt_r + 1'b1;
          end
`endif
        end
        ST_DB_UP: begin
          // A pressed sample is a bounce: resume where we were, counters
          // for hold time are left untouched.
          if (pressed_s) begin
            state_r  <= prior_r;
            db_cnt_r <= {DB_W{1'b0}};
          end else if (db_cnt_r >= DB_LAST) begin
            state_r       <= ST_IDLE;
            key_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else if (db_cnt_r != DB_MAX) begin
            db_cnt_r <= db_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          key_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: N_KEYS independent debounced key channels with press,
// release, long-press and (optional) auto-repeat events.
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   key_in     : raw key pins, pressed level set by ACTIVE_LOW
//   key_en     : per-channel enable
//   key_level  : debounced pressed level per channel
//   press_pulse, release_pulse, long_pulse, repeat_pulse : event strobes
//   any_press  : OR of press_pulse
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int N_KEYS       = 7,
  parameter int DEBOUNCE_CYC = 200000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] key_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              any_press
);

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
    key_event_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .key_raw       (key_in[gi]),
      .key_en        (key_en[gi]),
      .key_level     (key_level[gi]),
      .press_pulse   (press_pulse[gi]),
      .release_pulse (release_pulse[gi]),
      .long_pulse    (long_pulse[gi]),
      .repeat_pulse  (repeat_pulse[gi])
    );
  end

  // Built from registered strobes so it lines up with press_pulse.
  assign any_press = |press_pulse;

endmodule
